// File: rtl/mem_arbiter_if.sv
// Client and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; the master modport drives clients and memory.
interface mem_arbiter_if #(
  parameter int TAG_W = 4
) ();
  logic [31:0]      if_addr;
  logic [1:0]       if_command;
  logic             if_stall;
  logic [31:0]      if_rdata;
  logic             if_rdata_valid;

  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [1:0]       dm_command;
  logic             dm_stall;
  logic [31:0]      dm_rdata;
  logic             dm_rdata_valid;

  logic [31:0]      proc2mem_addr;
  logic [31:0]      proc2mem_data;
  logic [1:0]       proc2mem_command;
  logic [TAG_W-1:0] mem2proc_response;
  logic [31:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  logic             spurious_tag;

  modport slave (
    input  if_addr, if_command,
    input  dm_addr, dm_wdata, dm_command,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output if_stall, if_rdata, if_rdata_valid,
    output dm_stall, dm_rdata, dm_rdata_valid,
    output proc2mem_addr, proc2mem_data, proc2mem_command,
    output spurious_tag
  );

  modport master (
    output if_addr, if_command,
    output dm_addr, dm_wdata, dm_command,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  if_stall, if_rdata, if_rdata_valid,
    input  dm_stall, dm_rdata, dm_rdata_valid,
    input  proc2mem_addr, proc2mem_data, proc2mem_command,
    input  spurious_tag
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (instruction fetch / data memory) arbiter in front of one tagged memory.
// Tracks tag ownership so each completing load is routed back to the client that issued it.
module mem_arbiter #(
  parameter int TAG_W        = 4,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int N_TAGS = 1 << TAG_W;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int ST_W   = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUT);
  localparam logic [ST_W-1:0]  ST_LIMIT  = ST_W'(STARVE_LIMIT);
  localparam logic [1:0]       CMD_NONE  = 2'd0;
  localparam logic [1:0]       CMD_LOAD  = 2'd1;
  localparam logic [1:0]       CMD_STORE = 2'd2;
  localparam logic             OWN_IF    = 1'b0;
  localparam logic             OWN_DM    = 1'b1;

  logic [N_TAGS-1:0] tag_valid_q, tag_valid_d;
  logic [N_TAGS-1:0] tag_owner_q, tag_owner_d;
  logic [CNT_W-1:0]  if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0]  dm_cnt_q, dm_cnt_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              spurious_q, spurious_d;

  logic if_req, if_elig, dm_req, dm_elig;
  logic grant_if, grant_dm, resp_ok;
  logic alloc, alloc_owner;
  logic cpl_any, cpl_hit, cpl_spur, cpl_owner;
  logic if_inc, if_dec, dm_inc, dm_dec;

  // Arbitration: DM by default, IF when DM has nothing eligible or IF has starved long enough.
  always_comb begin
    if_req   = (bus.if_command == CMD_LOAD);
    if_elig  = if_req && (if_cnt_q != MAX_CNT);
    dm_req   = (bus.dm_command == CMD_LOAD) || (bus.dm_command == CMD_STORE);
    dm_elig  = dm_req && !((bus.dm_command == CMD_LOAD) && (dm_cnt_q == MAX_CNT));
    grant_if = !rst && if_elig && (!dm_elig || (starve_q == ST_LIMIT));
    grant_dm = !rst && dm_elig && !grant_if;
    resp_ok  = (bus.mem2proc_response != '0);
  end

  always_comb begin
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.proc2mem_command = CMD_NONE;
    if (grant_dm) begin
      bus.proc2mem_addr    = bus.dm_addr;
      bus.proc2mem_data    = bus.dm_wdata;
      bus.proc2mem_command = bus.dm_command;
    end else if (grant_if) begin
      bus.proc2mem_addr    = bus.if_addr;
      bus.proc2mem_command = CMD_LOAD;
    end
  end

  always_comb begin
    if (rst) begin
      bus.if_stall = 1'b1;
      bus.dm_stall = 1'b1;
    end else begin
      bus.if_stall = grant_if ? !resp_ok : if_req;
      bus.dm_stall = grant_dm ? !resp_ok : dm_req;
    end
  end

  // Only accepted loads claim a tag; stores complete without a response path.
  always_comb begin
    alloc       = (grant_if || grant_dm) && resp_ok && (bus.proc2mem_command == CMD_LOAD);
    alloc_owner = grant_dm ? OWN_DM : OWN_IF;
  end

  always_comb begin
    cpl_any   = !rst && (bus.mem2proc_tag != '0);
    cpl_hit   = cpl_any && tag_valid_q[bus.mem2proc_tag];
    cpl_spur  = cpl_any && !tag_valid_q[bus.mem2proc_tag];
    cpl_owner = tag_owner_q[bus.mem2proc_tag];

    bus.if_rdata_valid = cpl_hit && (cpl_owner == OWN_IF);
    bus.dm_rdata_valid = cpl_hit && (cpl_owner == OWN_DM);
    bus.if_rdata       = bus.if_rdata_valid ? bus.mem2proc_data : '0;
    bus.dm_rdata       = bus.dm_rdata_valid ? bus.mem2proc_data : '0;
    bus.spurious_tag   = spurious_q;
  end

  // Per-entry update: a same-cycle allocation overrides the retiring completion.
  for (genvar gi = 0; gi < N_TAGS; gi++) begin : g_tag
    logic alloc_here, clear_here;
    assign alloc_here = alloc && (bus.mem2proc_response == TAG_W'(gi));
    assign clear_here = cpl_hit && (bus.mem2proc_tag == TAG_W'(gi));
    assign tag_valid_d[gi] = alloc_here ? 1'b1
                           : clear_here ? 1'b0
                           : tag_valid_q[gi];
    assign tag_owner_d[gi] = alloc_here ? alloc_owner : tag_owner_q[gi];
  end

  always_comb begin
    if_inc = alloc && (alloc_owner == OWN_IF);
    dm_inc = alloc && (alloc_owner == OWN_DM);
    if_dec = cpl_hit && (cpl_owner == OWN_IF);
    dm_dec = cpl_hit && (cpl_owner == OWN_DM);

    if_cnt_d = if_cnt_q + CNT_W'(if_inc) - CNT_W'(if_dec);
    dm_cnt_d = dm_cnt_q + CNT_W'(dm_inc) - CNT_W'(dm_dec);

    starve_d = '0;
    if (if_req && !grant_if) begin
      starve_d = (starve_q == ST_LIMIT) ? starve_q : starve_q + 1'b1;
    end

    spurious_d = spurious_q || cpl_spur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q <= '0;
      tag_owner_q <= '0;
      if_cnt_q    <= '0;
      dm_cnt_q    <= '0;
      starve_q    <= '0;
      spurious_q  <= 1'b0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      if_cnt_q    <= if_cnt_d;
      dm_cnt_q    <= dm_cnt_d;
      starve_q    <= starve_d;
      spurious_q  <= spurious_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-client tagged-memory arbiter between the processor's instruction-fetch port (pc_addr/im_command) and data-memory port (proc2Dmem_*), on one side, and a single unified mem instance on the other. It forwards one request per cycle, records which client owns each returned tag, and routes each completing load back to its client with a one-cycle valid pulse. Clients are stalled while their request is not accepted.

Parameters:
TAG_W, 4, width of the mem response and tag buses; tag 0 means "none/rejected".
MAX_OUT, 4, maximum outstanding loads per client; range 1 to 2^TAG_W-1.
STARVE_LIMIT, 8, consecutive cycles IF may lose arbitration before it gets priority for one cycle.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_addr  in  32  instruction fetch address
if_command  in  2  fetch command: 0 NONE, 1 LOAD, 2 STORE (STORE from IF is illegal; treated as NONE)
if_stall  out  1  IF request not accepted this cycle
if_rdata  out  32  returned instruction
if_rdata_valid  out  1  one-cycle pulse; if_rdata valid
dm_addr  in  32  data address
dm_wdata  in  32  store data
dm_command  in  2  0 NONE, 1 LOAD, 2 STORE
dm_stall  out  1  DM request not accepted this cycle
dm_rdata  out  32  returned load data
dm_rdata_valid  out  1  one-cycle pulse; dm_rdata valid
proc2mem_addr  out  32  to mem
proc2mem_data  out  32  to mem
proc2mem_command  out  2  to mem
mem2proc_response  in  TAG_W  same-cycle accept tag; 0 = rejected
mem2proc_data  in  32  completion data
mem2proc_tag  in  TAG_W  completing tag; 0 = none
spurious_tag  out  1  sticky: a completion arrived for an unowned tag

Behaviour:
- Grant (combinational): default DM wins when dm_command != NONE; IF wins when DM idle, DM blocked by MAX_OUT, or starve_cnt == STARVE_LIMIT (then IF wins even if DM requests).
- A LOAD is blocked (not presented, client stalled) when that client's outstanding count == MAX_OUT. STOREs are never blocked by MAX_OUT.
- proc2mem_* = winner's addr/data/command; NONE if no eligible request. proc2mem_data = dm_wdata for DM, 0 for IF.
- Stall: client with command != NONE that is not granted -> stall=1. Granted client -> stall = (mem2proc_response == 0). Idle client -> stall=0.
- Accept = granted command != NONE and response != 0. Accepted LOAD: on the clock edge, table[response] <= {valid=1, owner}; owner outstanding count +1. Accepted STORE: no table entry.
- Completion: mem2proc_tag != 0 and table[tag].valid -> same-cycle (combinational) owner's rdata = mem2proc_data, owner's rdata_valid=1; entry cleared and count -1 at the edge. Non-owner rdata_valid=0; rdata holds 0 when not valid.
- Completion on tag with no valid entry: ignored, spurious_tag <= 1 (sticky until reset).
- Same cycle allocate and complete of the same tag: complete routed to old owner, new allocation wins in the table; counts update both (net 0 if same owner).
- Same-cycle increment and decrement on one client's count: count unchanged.
- starve_cnt: +1 (saturating at STARVE_LIMIT) each cycle IF has a request and is not granted; reset to 0 when IF granted or IF idle.
- Reset (synchronous, active-high): table all invalid, counts 0, starve_cnt 0, spurious_tag 0. While rst=1: proc2mem_command=NONE, if_stall=dm_stall=1, both rdata_valid=0. Completions arriving during reset are discarded. Reset mid-transaction drops all in-flight ownership; later completions for those tags raise spurious_tag.

Test Plan:
- Single IF LOAD 0x00000010, response=3, tag 3 with data 0x00000013 two cycles later -> if_stall 0 on issue, if_rdata_valid pulse with 0x00000013, dm_rdata_valid stays 0.
- Both request same cycle (IF LOAD 0x20, DM LOAD 0x100) -> DM granted, if_stall=1; next cycle IF granted; completions tag order reversed -> each data returned to correct client.
- DM LOAD with response=0 for 3 cycles then 5 -> dm_stall=1 for 3 cycles, 0 on 4th; table[5] owned by DM.
- DM issues loads continuously, IF requesting -> IF granted on 9th cycle (STARVE_LIMIT=8), starve_cnt returns to 0.
- IF 4 outstanding loads (MAX_OUT=4), 5th request -> not presented, if_stall=1 until one completes, then issued the same cycle the completion retires... next cycle.
- Completion tag 7 with no entry -> no valid pulse, spurious_tag=1 held; rst asserted mid-traffic -> all outputs at reset values, counts 0.
